// File: rtl/ddc_capture_ctrl_if.sv
// Bundle of configuration, decimated-sample and captured-frame signals
// between the capture controller (master) and its environment (slave).
interface ddc_capture_ctrl_if;
   logic        s_cfg_valid;
   logic [31:0] s_cfg_data;
   logic        s_cfg_ready;
   logic        start;
   logic [31:0] m_convert_config_data;
   logic [47:0] s_sample_data;
   logic        s_sample_valid;
   logic [47:0] m_frame_data;
   logic        m_frame_valid;
   logic        m_frame_ready;
   logic        m_frame_last;
   logic        busy;
   logic        frame_done;
   logic        overrun;

   modport master (
      input  s_cfg_valid, s_cfg_data, start, s_sample_data, s_sample_valid, m_frame_ready,
      output s_cfg_ready, m_convert_config_data, m_frame_data, m_frame_valid, m_frame_last,
             busy, frame_done, overrun
   );

   modport slave (
      output s_cfg_valid, s_cfg_data, start, s_sample_data, s_sample_valid, m_frame_ready,
      input  s_cfg_ready, m_convert_config_data, m_frame_data, m_frame_valid, m_frame_last,
             busy, frame_done, overrun
   );
endinterface

// File: rtl/ddc_capture_ctrl.sv
// Retune / settle / single-frame capture sequencer between the DDS decimator
// and the FFT/UART stage; one output register with valid/ready/last.
module ddc_capture_ctrl #(
   parameter int unsigned FRAME_LEN      = 1024,
   parameter int unsigned SETTLE_SAMPLES = 4,
   parameter logic [31:0] RESET_K        = 32'h0000_0000
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   ddc_capture_ctrl_if.master   bus
);
   localparam int unsigned FCW = $clog2(FRAME_LEN) + 1;
   localparam int unsigned SCW = $clog2(SETTLE_SAMPLES) + 1;
   localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN - 1);
   localparam logic [SCW-1:0] SETTLE_TGT = SCW'(SETTLE_SAMPLES);

   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CAPTURE, DONE} state_t;

   state_t         state_r;
   logic [31:0]    config_r;
   logic [47:0]    data_r;
   logic           valid_r;
   logic           last_r;
   logic           done_r;
   logic           overrun_r;
   logic           pending_r;
   logic [FCW-1:0] frame_cnt_r;
   logic [SCW-1:0] settle_cnt_r;

   logic           handoff_s;
   logic           load_ok_s;
   logic [SCW-1:0] settle_next_s;

   // Output-register handshake terms and next settle count
   always_comb begin
      handoff_s     = valid_r && bus.m_frame_ready;
      load_ok_s     = !valid_r || bus.m_frame_ready;
      settle_next_s = settle_cnt_r + SCW'(1);
   end

   // Sequencer FSM with output register; a handoff frees the register unless refilled below
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_r      <= IDLE;
         config_r     <= RESET_K;
         data_r       <= 48'h0;
         valid_r      <= 1'b0;
         last_r       <= 1'b0;
         done_r       <= 1'b0;
         overrun_r    <= 1'b0;
         pending_r    <= 1'b0;
         frame_cnt_r  <= '0;
         settle_cnt_r <= '0;
      end else begin
         done_r <= 1'b0;
         if (handoff_s) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
         end
         case (state_r)
            IDLE: begin
               if (bus.s_cfg_valid) begin
                  config_r  <= bus.s_cfg_data;
                  pending_r <= bus.start;
                  state_r   <= APPLY;
               end else if (bus.start) begin
                  overrun_r   <= 1'b0;
                  frame_cnt_r <= '0;
                  state_r     <= CAPTURE;
               end
            end
            APPLY: begin
               settle_cnt_r <= '0;
               if (bus.start) pending_r <= 1'b1;
               state_r <= SETTLE;
            end
            SETTLE: begin
               if (bus.start) pending_r <= 1'b1;
               if (bus.s_sample_valid) begin
                  settle_cnt_r <= settle_next_s;
                  if (settle_next_s == SETTLE_TGT) begin
                     if (pending_r || bus.start) begin
                        pending_r   <= 1'b0;
                        overrun_r   <= 1'b0;
                        frame_cnt_r <= '0;
                        state_r     <= CAPTURE;
                     end else begin
                        state_r <= IDLE;
                     end
                  end
               end
            end
            CAPTURE: begin
               // The decimator cannot be stalled, so a sample meeting a full register is lost
               if (bus.s_sample_valid) begin
                  if (load_ok_s) begin
                     valid_r     <= 1'b1;
                     data_r      <= bus.s_sample_data;
                     last_r      <= (frame_cnt_r == FRAME_LAST);
                     frame_cnt_r <= frame_cnt_r + FCW'(1);
                     if (frame_cnt_r == FRAME_LAST) state_r <= DONE;
                  end else begin
                     overrun_r <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (handoff_s && last_r) begin
                  done_r  <= 1'b1;
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign bus.s_cfg_ready           = (state_r == IDLE) && !sys_rst;
   assign bus.busy                  = (state_r != IDLE);
   assign bus.m_convert_config_data = config_r;
   assign bus.m_frame_data          = data_r;
   assign bus.m_frame_valid         = valid_r;
   assign bus.m_frame_last          = last_r;
   assign bus.frame_done            = done_r;
   assign bus.overrun               = overrun_r;
endmodule

// File: tb/tb_ddc_capture_ctrl.sv
// Self-checking bench: two controller builds (1024/4 and 2/1) against a
// per-sample reference model of the retune/settle/capture rules.
module tb_ddc_capture_ctrl;
   localparam int          FL0 = 1024;
   localparam int          SS0 = 4;
   localparam int          FL1 = 2;
   localparam int          SS1 = 1;
   localparam logic [31:0] RK0 = 32'h0000_0000;
   localparam logic [31:0] RK1 = 32'hCAFE_0001;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #10 sys_clk = ~sys_clk;

   ddc_capture_ctrl_if bus0 ();
   ddc_capture_ctrl_if bus1 ();

   ddc_capture_ctrl #(.FRAME_LEN(FL0), .SETTLE_SAMPLES(SS0), .RESET_K(RK0)) dut0 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus0));
   ddc_capture_ctrl #(.FRAME_LEN(FL1), .SETTLE_SAMPLES(SS1), .RESET_K(RK1)) dut1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus1));

   typedef enum int {M_IDLE, M_APPLY, M_SETTLE, M_CAP, M_DONE} mph_t;
   typedef struct {
      bit          cv;
      logic [31:0] cd;
      bit          st;
      bit          sv;
      logic [47:0] sd;
      bit          rdy;
   } in_t;

   // reference model, one slot per build
   mph_t        mph[2];
   logic [31:0] mcfg[2];
   logic [47:0] mdata[2];
   bit          mocc[2], mlast[2], mdone[2], movr[2], mpend[2];
   int          msc[2], mfc[2], drops[2], recv_cap[2];
   int          fl[2] = '{FL0, FL1};
   int          ss[2] = '{SS0, SS1};

   int          compared = 0;
   int          mismatched = 0;
   int          obs_done[2] = '{0, 0};
   logic [47:0] got_q[$];
   logic [47:0] sent_q[$];
   int          last_idx = -1;
   int          hs1 = 0, lastcnt1 = 0, bad1 = 0;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(int d, bit rst, in_t i);
      bit hs, was_last;
      hs       = mocc[d] && i.rdy;
      was_last = mlast[d];
      mdone[d] = 1'b0;
      if (rst) begin
         mph[d] = M_IDLE; mcfg[d] = (d == 0) ? RK0 : RK1; mocc[d] = 1'b0; mlast[d] = 1'b0;
         mdata[d] = 48'h0; movr[d] = 1'b0; mpend[d] = 1'b0; msc[d] = 0; mfc[d] = 0;
      end else begin
         if (hs) begin mocc[d] = 1'b0; mlast[d] = 1'b0; end
         case (mph[d])
            M_IDLE: begin
               if (i.cv) begin mcfg[d] = i.cd; mpend[d] = i.st; mph[d] = M_APPLY; end
               else if (i.st) begin movr[d] = 1'b0; mfc[d] = 0; mph[d] = M_CAP; end
            end
            M_APPLY: begin msc[d] = 0; if (i.st) mpend[d] = 1'b1; mph[d] = M_SETTLE; end
            M_SETTLE: begin
               if (i.st) mpend[d] = 1'b1;
               if (i.sv) begin
                  msc[d]++;
                  if (msc[d] == ss[d]) begin
                     if (mpend[d]) begin
                        mpend[d] = 1'b0; movr[d] = 1'b0; mfc[d] = 0; mph[d] = M_CAP;
                     end else mph[d] = M_IDLE;
                  end
               end
            end
            M_CAP: begin
               if (i.sv) begin
                  recv_cap[d]++;
                  if (!mocc[d]) begin
                     mocc[d] = 1'b1; mdata[d] = i.sd; mfc[d]++;
                     mlast[d] = (mfc[d] == fl[d]);
                     if (mfc[d] == fl[d]) mph[d] = M_DONE;
                  end else begin
                     movr[d] = 1'b1; drops[d]++;
                  end
               end
            end
            M_DONE: if (hs && was_last) begin mdone[d] = 1'b1; mph[d] = M_IDLE; end
            default: ;
         endcase
      end
   endtask

   task automatic compare_outs(int d, logic v, logic [47:0] dat, logic l, logic b, logic fd,
                               logic ov, logic [31:0] cfg, logic cr);
      check($sformatf("d%0d_valid", d), v, mocc[d]);
      if (mocc[d]) begin
         check($sformatf("d%0d_data", d), dat, mdata[d]);
         check($sformatf("d%0d_last", d), l, mlast[d]);
      end
      check($sformatf("d%0d_busy", d), b, mph[d] != M_IDLE);
      check($sformatf("d%0d_frame_done", d), fd, mdone[d]);
      check($sformatf("d%0d_overrun", d), ov, movr[d]);
      check($sformatf("d%0d_config", d), cfg, mcfg[d]);
      check($sformatf("d%0d_cfg_ready", d), cr, (mph[d] == M_IDLE) && !sys_rst);
   endtask

   task automatic tick();
      in_t i0, i1;
      bit  r;
      r = sys_rst;
      i0.cv = bus0.s_cfg_valid; i0.cd = bus0.s_cfg_data; i0.st = bus0.start;
      i0.sv = bus0.s_sample_valid; i0.sd = bus0.s_sample_data; i0.rdy = bus0.m_frame_ready;
      i1.cv = bus1.s_cfg_valid; i1.cd = bus1.s_cfg_data; i1.st = bus1.start;
      i1.sv = bus1.s_sample_valid; i1.sd = bus1.s_sample_data; i1.rdy = bus1.m_frame_ready;
      if (bus0.m_frame_valid === 1'b1 && bus0.m_frame_ready === 1'b1) begin
         got_q.push_back(bus0.m_frame_data);
         if (bus0.m_frame_last === 1'b1 && last_idx < 0) last_idx = got_q.size() - 1;
      end
      if (bus1.m_frame_valid === 1'b1 && bus1.m_frame_ready === 1'b1) begin
         if (bus1.m_frame_last === 1'b1) begin
            lastcnt1++;
            if (hs1 % 2 == 0) bad1++;
         end
         hs1++;
      end
      @(posedge sys_clk);
      model_edge(0, r, i0);
      model_edge(1, r, i1);
      #1;
      if (bus0.frame_done === 1'b1) obs_done[0]++;
      if (bus1.frame_done === 1'b1) obs_done[1]++;
      compare_outs(0, bus0.m_frame_valid, bus0.m_frame_data, bus0.m_frame_last, bus0.busy,
                   bus0.frame_done, bus0.overrun, bus0.m_convert_config_data, bus0.s_cfg_ready);
      compare_outs(1, bus1.m_frame_valid, bus1.m_frame_data, bus1.m_frame_last, bus1.busy,
                   bus1.frame_done, bus1.overrun, bus1.m_convert_config_data, bus1.s_cfg_ready);
   endtask

   function automatic logic [47:0] rnd_sample();
      return {2'b00, 22'($urandom), 2'b00, 22'($urandom)};
   endfunction

   task automatic send0();
      bus0.s_sample_data = rnd_sample(); bus0.s_sample_valid = 1'b1;
      sent_q.push_back(bus0.s_sample_data);
      tick();
      bus0.s_sample_valid = 1'b0;
   endtask

   task automatic send1();
      bus1.s_sample_data = rnd_sample(); bus1.s_sample_valid = 1'b1;
      tick();
      bus1.s_sample_valid = 1'b0;
   endtask

   initial begin
      int bad;
      int burst;
      bus0.s_cfg_valid = 1'b0; bus0.s_cfg_data = 32'h0; bus0.start = 1'b0;
      bus0.s_sample_valid = 1'b0; bus0.s_sample_data = 48'h0; bus0.m_frame_ready = 1'b0;
      bus1.s_cfg_valid = 1'b0; bus1.s_cfg_data = 32'h0; bus1.start = 1'b0;
      bus1.s_sample_valid = 1'b0; bus1.s_sample_data = 48'h0; bus1.m_frame_ready = 1'b0;
      for (int d = 0; d < 2; d++) begin drops[d] = 0; recv_cap[d] = 0; end

      // reset
      sys_rst = 1'b1;
      repeat (3) tick();
      check("rst_cfg0", bus0.m_convert_config_data, RK0);
      check("rst_cfg1", bus1.m_convert_config_data, RK1);
      check("rst_valid0", bus0.m_frame_valid, 1'b0);
      sys_rst = 1'b0;
      tick();

      // 1: cfg + start together, slow samples, ready high
      bus0.m_frame_ready = 1'b1;
      bus0.s_cfg_valid = 1'b1; bus0.s_cfg_data = 32'h0000_0A3D; bus0.start = 1'b1;
      tick();
      bus0.s_cfg_valid = 1'b0; bus0.start = 1'b0;
      check("t1_cfg_next", bus0.m_convert_config_data, 32'h0000_0A3D);
      check("t1_busy", bus0.busy, 1'b1);
      for (int i = 0; i < 1100 && obs_done[0] == 0; i++) begin
         repeat (15) tick();
         send0();
      end
      repeat (20) tick();
      check("t1_fwd_count", got_q.size(), 64'd1024);
      bad = 0;
      for (int k = 0; k < got_q.size(); k++)
         if (k + 4 >= sent_q.size() || got_q[k] !== sent_q[k + 4]) bad++;
      check("t1_order_bad", bad, 64'd0);
      check("t1_last_idx", last_idx, 64'd1023);
      check("t1_done_once", obs_done[0], 64'd1);
      check("t1_overrun", bus0.overrun, 1'b0);

      // 2: start alone, ready low so the second sample is dropped
      got_q.delete(); sent_q.delete(); obs_done[0] = 0;
      bus0.m_frame_ready = 1'b0;
      bus0.start = 1'b1; tick(); bus0.start = 1'b0;
      send0();
      repeat (5) tick();
      send0();
      check("t2_overrun_set", bus0.overrun, 1'b1);
      check("t2_held_data", bus0.m_frame_data, sent_q[0]);
      bus0.m_frame_ready = 1'b1;
      for (int i = 0; i < 1100 && obs_done[0] == 0; i++) begin
         send0();
         repeat (3) tick();
      end
      check("t2_fwd_count", got_q.size(), 64'd1024);
      check("t2_first", got_q[0], sent_q[0]);
      check("t2_second", got_q[1], sent_q[2]);
      check("t2_overrun_sticky", bus0.overrun, 1'b1);
      repeat (2) tick();
      bus0.start = 1'b1; tick(); bus0.start = 1'b0;
      check("t2_overrun_cleared", bus0.overrun, 1'b0);

      // 3: random 50% ready with back-to-back sample pairs
      got_q.delete(); obs_done[0] = 0; drops[0] = 0; recv_cap[0] = 0; burst = 0;
      for (int c = 0; c < 30000 && obs_done[0] == 0; c++) begin
         bus0.m_frame_ready = 1'($urandom_range(0, 1));
         if (burst == 0 && $urandom_range(0, 2) == 0) burst = 2;
         if (burst > 0) begin
            bus0.s_sample_valid = 1'b1; bus0.s_sample_data = rnd_sample(); burst--;
         end else bus0.s_sample_valid = 1'b0;
         tick();
      end
      bus0.s_sample_valid = 1'b0; bus0.m_frame_ready = 1'b1;
      check("t3_fwd_count", got_q.size(), 64'd1024);
      check("t3_balance", got_q.size() + drops[0], recv_cap[0]);
      check("t3_done", obs_done[0], 64'd1);

      // 4: retune without capture; cfg offered while settling is refused
      got_q.delete();
      bus0.s_cfg_valid = 1'b1; bus0.s_cfg_data = 32'h1234_5678; tick();
      bus0.s_cfg_data = 32'hDEAD_BEEF;
      tick(); tick();
      check("t4_ready_low", bus0.s_cfg_ready, 1'b0);
      bus0.s_cfg_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send0();
         check("t4_busy", bus0.busy, (i < 3) ? 1'b1 : 1'b0);
         tick();
      end
      for (int i = 0; i < 3; i++) send0();
      check("t4_cfg", bus0.m_convert_config_data, 32'h1234_5678);
      check("t4_no_output", got_q.size(), 64'd0);

      // 5: reset at sample 500, then a fresh frame
      bus0.start = 1'b1; tick(); bus0.start = 1'b0;
      bus0.m_frame_ready = 1'b1;
      for (int i = 0; i < 499; i++) begin
         bus0.s_sample_valid = 1'b1; bus0.s_sample_data = rnd_sample(); tick();
      end
      bus0.s_sample_data = rnd_sample(); sys_rst = 1'b1; tick();
      check("t5_valid", bus0.m_frame_valid, 1'b0);
      check("t5_data", bus0.m_frame_data, 48'h0);
      check("t5_last", bus0.m_frame_last, 1'b0);
      check("t5_busy", bus0.busy, 1'b0);
      check("t5_cfg", bus0.m_convert_config_data, RK0);
      sys_rst = 1'b0; bus0.s_sample_valid = 1'b0;
      got_q.delete(); obs_done[0] = 0;
      repeat (3) tick();
      check("t5_no_done", obs_done[0], 64'd0);
      bus0.start = 1'b1; tick(); bus0.start = 1'b0;
      for (int i = 0; i < 1100 && obs_done[0] == 0; i++) begin
         send0();
         tick();
      end
      check("t5_fwd_count", got_q.size(), 64'd1024);
      check("t5_done", obs_done[0], 64'd1);

      // 6: short build, back-to-back frames, delayed ready on the last sample
      for (int f = 0; f < 3; f++) begin
         bus1.start = 1'b1;
         if (f == 2) begin bus1.s_cfg_valid = 1'b1; bus1.s_cfg_data = 32'h0000_1111; end
         tick();
         bus1.start = 1'b0; bus1.s_cfg_valid = 1'b0;
         if (f == 2) begin tick(); send1(); end
         bus1.m_frame_ready = 1'b1;
         send1(); send1();
         bus1.m_frame_ready = 1'b0;
         send1();
         repeat (9) tick();
         check("t6_waiting_done", obs_done[1], f);
         check("t6_busy", bus1.busy, 1'b1);
         bus1.m_frame_ready = 1'b1;
         tick();
         check("t6_frame_done", bus1.frame_done, 1'b1);
         check("t6_idle", bus1.busy, 1'b0);
      end
      tick();
      check("t6_handoffs", hs1, 64'd6);
      check("t6_last_count", lastcnt1, 64'd3);
      check("t6_last_pos", bad1, 64'd0);
      check("t6_frames", obs_done[1], 64'd3);
      check("t6_cfg", bus1.m_convert_config_data, 32'h0000_1111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/ddc_capture_ctrl.md
# ddc_capture_ctrl

Sequencing controller for the IQ down-conversion/decimation path. It accepts DDS frequency words from the UART configuration path and drives the `s_convert_config_data` input of the decimator. After each retune it discards the decimated samples still carrying the old frequency. On request, it captures one frame of FRAME_LEN 48-bit IQ samples and forwards them with valid/ready/last handshake toward the FFT/UART stage.

## Interface
- FRAME_LEN, 1024, decimated IQ samples per captured frame (≥2)
- SETTLE_SAMPLES, 4, decimated samples discarded after a retune (≥1), covers CIC/mult/DDS pipeline flush
- RESET_K, 32'h0000_0000, DDS config word driven after reset
- sys_clk  in  1  system clock (50 MHz); one clock, synchronous and active-high reset
- sys_rst  in  1  synchronous reset, active-high
- s_cfg_valid  in  1  new frequency word offered
- s_cfg_data  in  32  frequency word, K = f0·2^16/50 MHz in low bits
- s_cfg_ready  out  1  = (state==IDLE) && !sys_rst
- start  in  1  capture request, single-cycle pulse
- m_convert_config_data  out  32  registered DDS config word to decimator
- s_sample_data  in  48  {2'b0,I[21:0],2'b0,Q[21:0]} from decimator
- s_sample_valid  in  1  decimator output strobe (no backpressure possible)
- m_frame_data  out  48  captured sample
- m_frame_valid  out  1  output register holds a sample
- m_frame_ready  in  1  downstream accepts
- m_frame_last  out  1  marks FRAME_LEN-th sample
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when last sample handed off
- overrun  out  1  sticky: sample dropped due to backpressure; cleared on accepted start

## Operation
- States: IDLE, APPLY, SETTLE, CAPTURE, DONE.
- IDLE: s_cfg_valid=1 → latch s_cfg_data into m_convert_config_data, → APPLY. start=1 with no cfg → clear overrun, frame counter=0, → CAPTURE. Both same cycle → config applied and start latched as pending.
- APPLY: one cycle, settle counter=0, → SETTLE.
- SETTLE: each s_sample_valid increments settle counter; samples discarded. start seen in APPLY/SETTLE sets pending. When counter reaches SETTLE_SAMPLES: → CAPTURE if pending (clear pending, clear overrun, frame counter=0), else → IDLE.
- CAPTURE: on s_sample_valid, if output register empty or m_frame_ready=1 → load sample, frame counter++, m_frame_last = (counter==FRAME_LEN-1). Else sample dropped, overrun=1, counter unchanged. After loading the FRAME_LEN-th sample → DONE.
- DONE: wait for handshake of the last sample (m_frame_valid && m_frame_ready && m_frame_last) → frame_done pulse, → IDLE. Incoming samples ignored.
- start during CAPTURE/DONE ignored; s_cfg_valid outside IDLE not accepted (ready=0).
- Frame counter width clog2(FRAME_LEN)+1; settle counter width clog2(SETTLE_SAMPLES)+1; no wrap within a frame.

## Timing
- Reset (synchronous, sys_rst high at clock edge): state IDLE, m_convert_config_data=RESET_K, m_frame_valid=0, m_frame_last=0, m_frame_data=0, busy=0, frame_done=0, overrun=0, pending=0, counters 0. Reset mid-frame aborts immediately; no frame_done, output register cleared.
- s_cfg_valid accepted at edge t → m_convert_config_data new at t+1, busy=1 at t+1.
- Sample valid at edge t in CAPTURE → m_frame_valid/m_frame_data at t+1; held stable until m_frame_ready.
- Output handshake with new sample same cycle: register reloads, no bubble, no overrun.
- m_frame_valid drops the cycle after handshake unless reloaded.
- frame_done asserted the cycle after last handshake, with state IDLE/busy=0 at that same cycle.
- DONE→IDLE→next start: minimum 1 idle cycle.

## Test plan
- Reset then cfg 32'h0000_0A3D + start same cycle, 1 sample every 16 clocks, ready=1 → config updates at t+1, first 4 samples dropped, next FRAME_LEN forwarded in order, last flag on 1024th, frame_done once, overrun=0.
- start alone, ready held low after first sample, sample 2 arrives → sample 2 dropped, overrun=1, frame still completes with 1024 forwarded samples; next start clears overrun.
- Ready toggling 50% with samples every cycle in bursts of 2 → data never changes while valid && !ready; counts of forwarded + dropped = samples received in CAPTURE.
- cfg in IDLE without start → SETTLE consumes exactly 4 samples, returns IDLE, no m_frame_valid; s_cfg_valid during SETTLE sees ready=0 and is not applied.
- sys_rst asserted at sample 500 of a frame → next edge all outputs at reset values, config=RESET_K; fresh start yields complete frame.
- FRAME_LEN=2, SETTLE_SAMPLES=1 build: back-to-back starts → each frame exactly 2 samples, last on second, DONE waits for delayed ready (10 cycles) before frame_done.
